// File: rtl/debug_loader.sv
// debug_loader: UART command front end that loads program words into instruction memory and
// gates the CPU in run/single-step mode. Define DEBUG_PC_REPORT_EN to append the PC to RUN/STEP acks.
module debug_loader #(
    parameter int         ADDR_WIDTH = 10,
    parameter int         DATA_WIDTH = 32,
    parameter logic [7:0] CMD_LOAD   = 8'h4C,
    parameter logic [7:0] CMD_RUN    = 8'h52,
    parameter logic [7:0] CMD_STEP   = 8'h53,
    parameter logic [7:0] CMD_HALT   = 8'h48,
    parameter logic [7:0] ACK_BYTE   = 8'h06
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  imem_we,
    output logic                  cpu_enable,
    output logic                  cpu_reset,
    input  logic                  cpu_halt,
    input  logic [ADDR_WIDTH-1:0] pc_current,
    output logic                  busy
);
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, WORD, RUN, STEP, SEND} state_t;
    state_t state, state_nx;

    logic [7:0]            len_hi;
    logic [15:0]           words_left;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            byte_cnt;
    logic [DATA_WIDTH-9:0] asm_reg;
    logic                  last_wr;
    logic [1:0]            send_left;
    logic [1:0]            send_total;
    logic [7:0]            tx_byte;
    logic                  word_byte;
    logic                  word_done;
    logic                  enter_send;
    logic                  cpu_reset_nx;
    logic                  tx_start_nx;

    // last_wr blocks further bytes during the cycle the final word is being written
    assign word_byte  = (state == WORD) && rx_valid && !last_wr;
    assign word_done  = word_byte && (byte_cnt == 2'd3);
    assign enter_send = (state_nx == SEND) && (state != SEND);
    assign cpu_enable = (state == RUN) || (state == STEP);
    assign busy       = (state != IDLE);

`ifdef DEBUG_PC_REPORT_EN
    logic       pc_rep;
    logic [9:0] pc_snap;

    assign send_total = cpu_enable ? 2'd3 : 2'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_rep  <= 1'b0;
            pc_snap <= '0;
        end else if (enter_send) begin
            pc_rep  <= cpu_enable;
            pc_snap <= 10'(pc_current);
        end
    end

    always_comb begin
        tx_byte = ACK_BYTE;
        if (pc_rep && send_left == 2'd2)
            tx_byte = {6'b0, pc_snap[9:8]};
        else if (pc_rep && send_left == 2'd1)
            tx_byte = pc_snap[7:0];
    end
`else
    logic unused_pc;
    assign unused_pc  = ^pc_current;
    assign send_total = 2'd1;
    assign tx_byte    = ACK_BYTE;
`endif

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        cpu_reset_nx = 1'b0;
        tx_start_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_LOAD)
                        state_nx = LEN_HI;
                    else if (rx_data == CMD_RUN)
                        state_nx = RUN;
                    else if (rx_data == CMD_STEP)
                        state_nx = STEP;
                end
            end
            LEN_HI: if (rx_valid) state_nx = LEN_LO;
            LEN_LO: if (rx_valid) state_nx = ({len_hi, rx_data} == 16'd0) ? SEND : WORD;
            WORD: begin
                if (last_wr) begin
                    cpu_reset_nx = 1'b1;
                    state_nx     = SEND;
                end
            end
            RUN:  if (cpu_halt || (rx_valid && rx_data == CMD_HALT)) state_nx = SEND;
            STEP: state_nx = SEND;
            SEND: begin
                // one idle cycle after each pulse gives the transmitter time to raise tx_busy
                if (!tx_busy && !tx_start) begin
                    tx_start_nx = 1'b1;
                    if (send_left == 2'd1)
                        state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            len_hi     <= '0;
            words_left <= '0;
            addr       <= '0;
            byte_cnt   <= '0;
            asm_reg    <= '0;
            last_wr    <= 1'b0;
            send_left  <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
        end else begin
            imem_we   <= word_done;
            cpu_reset <= cpu_reset_nx;
            tx_start  <= tx_start_nx;
            last_wr   <= word_done && (words_left == 16'd1);
            if (state == LEN_HI && rx_valid)
                len_hi <= rx_data;
            if (state == LEN_LO && rx_valid) begin
                words_left <= {len_hi, rx_data};
                addr       <= '0;
                byte_cnt   <= '0;
            end
            if (word_byte) begin
                asm_reg  <= {asm_reg[DATA_WIDTH-17:0], rx_data};
                byte_cnt <= byte_cnt + 2'd1;
            end
            // address wraps naturally, so oversize loads overwrite from the bottom
            if (word_done) begin
                imem_addr  <= addr;
                imem_wdata <= {asm_reg, rx_data};
                addr       <= addr + ADDR_WIDTH'(1);
                words_left <= words_left - 16'd1;
            end
            if (enter_send)
                send_left <= send_total;
            else if (tx_start_nx)
                send_left <= send_left - 2'd1;
            if (tx_start_nx)
                tx_data <= tx_byte;
        end
    end
endmodule

// File: tb/tb_debug_loader.sv
// Self-checking bench for debug_loader: transaction-level expectation queues checked every cycle.
`timescale 1ns/1ps
module tb_debug_loader;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clock;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          imem_we;
    logic          cpu_enable;
    logic          cpu_reset;
    logic          cpu_halt;
    logic [AW-1:0] pc_current;
    logic          busy;

    logic          force_busy;
    logic          tx_model_busy;
    int            busy_cnt;
    assign tx_busy = force_busy | tx_model_busy;

    debug_loader dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_we(imem_we),
        .cpu_enable(cpu_enable), .cpu_reset(cpu_reset), .cpu_halt(cpu_halt),
        .pc_current(pc_current), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int               checks;
    int               errors;
    bit               exp_en;
    int               exp_rst;
    logic [AW+DW-1:0] exp_writes[$];
    logic [7:0]       exp_tx[$];
    logic [31:0]      load_words[$];
    logic [AW+DW-1:0] wr_log[$];
    logic [7:0]       tx_log[$];
    int               obs_rst;
    int               en_cnt;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Simple transmitter: busy for a random 1..4 cycles after each start pulse
    initial begin
        tx_model_busy = 1'b0;
        busy_cnt      = 0;
        forever begin
            @(posedge clock);
            #1;
            if (tx_start === 1'b1)
                busy_cnt = $urandom_range(1, 4);
            else if (busy_cnt > 0)
                busy_cnt--;
            tx_model_busy = (busy_cnt != 0);
        end
    end

    // Per-cycle comparison against the expectation queues
    initial begin
        logic [AW+DW-1:0] w;
        logic [7:0]       t;
        logic             prev_busy;
        prev_busy = 1'b0;
        forever begin
            @(negedge clock);
            chk("cpu_enable", 64'(cpu_enable), 64'(exp_en));
            if (cpu_enable === 1'b1)
                en_cnt++;
            if (imem_we === 1'b1) begin
                chk("we_enable_exclusive", 64'(cpu_enable), 64'd0);
                wr_log.push_back({imem_addr, imem_wdata});
                chk("write_expected", 64'(exp_writes.size() != 0), 64'd1);
                if (exp_writes.size() != 0) begin
                    w = exp_writes.pop_front();
                    chk("imem_write", 64'({imem_addr, imem_wdata}), 64'(w));
                end
            end
            if (tx_start === 1'b1) begin
                tx_log.push_back(tx_data);
                chk("tx_start_while_busy", 64'(prev_busy), 64'd0);
                chk("tx_expected", 64'(exp_tx.size() != 0), 64'd1);
                if (exp_tx.size() != 0) begin
                    t = exp_tx.pop_front();
                    chk("tx_data", 64'(tx_data), 64'(t));
                end
            end
            if (cpu_reset === 1'b1) begin
                obs_rst++;
                chk("cpu_reset_expected", 64'(exp_rst > 0), 64'd1);
                chk("cpu_reset_after_writes", 64'(exp_writes.size()), 64'd0);
                if (exp_rst > 0)
                    exp_rst--;
            end
            prev_busy = tx_busy;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    function automatic logic [7:0] pick_junk();
        logic [7:0] b;
        do b = 8'($urandom); while (b == 8'h4C || b == 8'h52 || b == 8'h53 || b == 8'h48);
        return b;
    endfunction

    task automatic clear_logs();
        wr_log.delete();
        tx_log.delete();
        obs_rst = 0;
        en_cnt  = 0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || busy !== 1'b0) && n < 500) begin
            tick();
            n++;
        end
        chk({name, "_tx_outstanding"}, 64'(exp_tx.size()), 64'd0);
        chk({name, "_writes_outstanding"}, 64'(exp_writes.size()), 64'd0);
        chk({name, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_tx_data"}, 64'(tx_data), 64'd0);
        chk({tag, "_tx_start"}, 64'(tx_start), 64'd0);
        chk({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
        chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
        chk({tag, "_imem_we"}, 64'(imem_we), 64'd0);
        chk({tag, "_cpu_enable"}, 64'(cpu_enable), 64'd0);
        chk({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic expect_cpu_ack();
        exp_tx.push_back(8'h06);
`ifdef DEBUG_PC_REPORT_EN
        exp_tx.push_back({6'b0, pc_current[9:8]});
        exp_tx.push_back(pc_current[7:0]);
`endif
    endtask

    task automatic do_load(input int n, input bit gaps);
        logic [31:0] w;
        logic [15:0] nn;
        nn = 16'(n);
        exp_tx.push_back(8'h06);
        if (n > 0)
            exp_rst++;
        send_byte(8'h4C);
        if (gaps) gap();
        send_byte(nn[15:8]);
        if (gaps) gap();
        send_byte(nn[7:0]);
        for (int i = 0; i < n; i++) begin
            if (load_words.size() != 0)
                w = load_words.pop_front();
            else
                w = $urandom;
            exp_writes.push_back({10'(i % 1024), w});
            for (int k = 3; k >= 0; k--) begin
                if (gaps) gap();
                send_byte(w[8*k +: 8]);
            end
        end
        wait_idle("load");
    endtask

    // mode 0: halt pin, 1: CMD_HALT byte, 2: both in the same cycle
    task automatic do_run(input int k, input int mode, input logic [AW-1:0] pc);
        pc_current = pc;
        expect_cpu_ack();
        send_byte(8'h52);
        exp_en = 1'b1;
        for (int i = 0; i < k; i++) begin
            if ($urandom_range(0, 3) == 0)
                send_byte(pick_junk());
            else
                tick();
        end
        if (mode != 1)
            cpu_halt = 1'b1;
        if (mode != 0) begin
            rx_data  = 8'h48;
            rx_valid = 1'b1;
        end
        tick();
        cpu_halt = 1'b0;
        rx_valid = 1'b0;
        exp_en   = 1'b0;
        wait_idle("run");
    endtask

    task automatic do_step(input logic [AW-1:0] pc, input int hold);
        int n0;
        pc_current = pc;
        expect_cpu_ack();
        n0 = tx_log.size();
        if (hold > 0)
            force_busy = 1'b1;
        send_byte(8'h53);
        exp_en = 1'b1;
        tick();
        exp_en = 1'b0;
        if (hold > 0) begin
            repeat (hold - 2) tick();
            chk("step_tx_withheld", 64'(tx_log.size()), 64'(n0));
            force_busy = 1'b0;
        end
        wait_idle("step");
    endtask

    initial begin
        checks = 0; errors = 0; exp_en = 1'b0; exp_rst = 0;
        obs_rst = 0; en_cnt = 0;
        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; cpu_halt = 1'b0;
        pc_current = '0; force_busy = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");
        reset = 1'b0;
        tick();

        // Two-word load with fixed data
        clear_logs();
        load_words.push_back(32'hDEADBEEF);
        load_words.push_back(32'h00000001);
        do_load(2, 1'b0);
        chk("load_write_count", 64'(wr_log.size()), 64'd2);
        chk("load_word0", 64'(wr_log[0]), 64'({10'd0, 32'hDEADBEEF}));
        chk("load_word1", 64'(wr_log[1]), 64'({10'd1, 32'h00000001}));
        chk("load_cpu_reset_pulses", 64'(obs_rst), 64'd1);
        chk("load_tx_count", 64'(tx_log.size()), 64'd1);
        chk("load_ack", 64'(tx_log[0]), 64'h06);

        // Zero-length load
        clear_logs();
        do_load(0, 1'b1);
        chk("zero_load_writes", 64'(wr_log.size()), 64'd0);
        chk("zero_load_cpu_reset", 64'(obs_rst), 64'd0);
        chk("zero_load_tx_count", 64'(tx_log.size()), 64'd1);

        // Run for 20 cycles then halt pin
        clear_logs();
        do_run(20, 0, 10'h2A5);
        chk("run_enable_cycles", 64'(en_cnt), 64'd21);
`ifdef DEBUG_PC_REPORT_EN
        chk("run_tx_count", 64'(tx_log.size()), 64'd3);
        chk("run_pc_hi", 64'(tx_log[1]), 64'h02);
        chk("run_pc_lo", 64'(tx_log[2]), 64'hA5);
`else
        chk("run_tx_count", 64'(tx_log.size()), 64'd1);
`endif
        chk("run_ack", 64'(tx_log[0]), 64'h06);

        // Step while transmitter is busy for 10 cycles
        clear_logs();
        do_step(10'h155, 10);
        chk("step_enable_cycles", 64'(en_cnt), 64'd1);
        chk("step_ack", 64'(tx_log[0]), 64'h06);

        // Reset in the middle of a three-word load
        clear_logs();
        exp_writes.push_back({10'd0, 32'h11223344});
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_outputs_zero("midload_reset");
        chk("midload_write_count", 64'(wr_log.size()), 64'd1);
        chk("midload_word0", 64'(wr_log[0]), 64'({10'd0, 32'h11223344}));
        send_byte(8'h48);
        repeat (10) tick();
        chk("midload_halt_ignored_tx", 64'(tx_log.size()), 64'd0);
        chk("midload_halt_ignored_busy", 64'(busy), 64'd0);

        // Halt pin and CMD_HALT byte in the same cycle
        clear_logs();
        do_run(5, 2, 10'h3C1);
        chk("simul_enable_cycles", 64'(en_cnt), 64'd6);
`ifdef DEBUG_PC_REPORT_EN
        chk("simul_tx_count", 64'(tx_log.size()), 64'd3);
`else
        chk("simul_tx_count", 64'(tx_log.size()), 64'd1);
`endif

        // Randomized command mix
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0: do_load($urandom_range(0, 5), 1'b1);
                1: do_run($urandom_range(0, 15), $urandom_range(0, 2), 10'($urandom));
                2: do_step(10'($urandom), 0);
                3: begin
                    send_byte(pick_junk());
                    chk("junk_ignored_busy", 64'(busy), 64'd0);
                    gap();
                end
                default: do_step(10'($urandom), $urandom_range(3, 8));
            endcase
        end

        // Oversize load wraps the address
        clear_logs();
        do_load(1026, 1'b0);
        chk("wrap_write_count", 64'(wr_log.size()), 64'd1026);
        chk("wrap_addr_1024", 64'(wr_log[1024][AW+DW-1:DW]), 64'd0);
        chk("wrap_addr_1025", 64'(wr_log[1025][AW+DW-1:DW]), 64'd1);

        chk("cpu_reset_pending_at_end", 64'(exp_rst), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
